// File: rtl/nf_cf_array.sv
// Pipelined evaluator of table-defined quadratic component functions over three-share nibbles.
// Every function output is registered on its own before any cross-function XOR (glitch barrier).
module nf_cf_array #(
    parameter int CHANNELS = 16,
    parameter int NUM_FN = 18,
    parameter int GROUP = 6,
    parameter int OUT_REG = 1,
    parameter logic [NUM_FN*21-1:0] FN_TABLE = '0,
    localparam int OUT_W = NUM_FN / GROUP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [12*CHANNELS-1:0]      in_x,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_W*CHANNELS-1:0]   out_q
);

    if (NUM_FN % GROUP != 0) begin : g_bad_group
        $fatal(1, "nf_cf_array: NUM_FN must be a multiple of GROUP");
    end

    logic [CHANNELS*NUM_FN-1:0] f_all;
    logic [CHANNELS*NUM_FN-1:0] s1;
    logic [CHANNELS*OUT_W-1:0]  comp;
    logic                       v1;
    logic                       s1_drain;
    logic                       load1;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
        logic [11:0] x;
        assign x = in_x[12*n +: 12];

        for (genvar k = 0; k < NUM_FN; k++) begin : g_fn
            localparam logic [20:0] ENT = FN_TABLE[21*k +: 21];
            localparam logic        CONST_BIT = ENT[20];
            localparam logic [11:0] MASK = ENT[19:8];
            localparam int          IDX_I = int'(ENT[7:4]);
            localparam int          IDX_J = int'(ENT[3:0]);
            logic prod;
            // Out-of-range product indices disable the quadratic term; i == j degenerates to x[i].
            if (IDX_I < 12 && IDX_J < 12) begin : g_prod
                assign prod = x[IDX_I] & x[IDX_J];
            end else begin : g_no_prod
                assign prod = 1'b0;
            end
            assign f_all[n*NUM_FN + k] = CONST_BIT ^ (^(MASK & x)) ^ prod;
        end

        for (genvar m = 0; m < OUT_W; m++) begin : g_cmp
            assign comp[n*OUT_W + m] = ^s1[n*NUM_FN + GROUP*m +: GROUP];
        end
    end

    // Handshake: a beat transfers on an edge where valid & ready are both high. Ready may depend
    // combinationally on the downstream ready; valid never depends on ready. Flush kills all
    // valid flags and blocks every data-register load for that edge.
    assign in_ready = !v1 | s1_drain;
    assign load1    = in_valid & in_ready & !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else begin
            if (flush) begin
                v1 <= 1'b0;
            end else if (in_ready) begin
                v1 <= in_valid;
            end
            if (load1) begin
                s1 <= f_all;
            end
        end
    end

    if (OUT_REG != 0) begin : g_s2
        logic                      v2;
        logic [CHANNELS*OUT_W-1:0] s2;

        assign s1_drain  = !v2 | out_ready;
        assign out_valid = v2;
        assign out_q     = s2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v2 <= 1'b0;
                s2 <= '0;
            end else begin
                if (flush) begin
                    v2 <= 1'b0;
                end else if (s1_drain) begin
                    v2 <= v1;
                end
                if (v1 & s1_drain & !flush) begin
                    s2 <= comp;
                end
            end
        end
    end else begin : g_no_s2
        assign s1_drain  = out_ready;
        assign out_valid = v1;
        assign out_q     = comp;
    end

endmodule

// File: tb/tb_nf_cf_array.sv
// Directed bench for nf_cf_array: several small configurations plus a default-size
// three-share configuration checked against the unmasked reference function.
module tb_nf_cf_array;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [20:0] ent(input logic c, input logic [11:0] mask,
                                        input logic [3:0] i, input logic [3:0] j);
        return {c, mask, i, j};
    endfunction

    function automatic logic [12*21-1:0] id_table();
        logic [12*21-1:0] t;
        t = '0;
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) t[21*k +: 21] = ent(1'b0, 12'h000, 4'(k), 4'(k));
            else            t[21*k +: 21] = ent(1'b0, 12'(1 << k), 4'hF, 4'hF);
        end
        return t;
    endfunction

    // Three-share sharing of g = a&b ^ c ^ d; share s avoids every input share with index s.
    function automatic logic [18*21-1:0] prince_table();
        logic [20:0] e [18];
        logic [18*21-1:0] t;
        e[0]  = ent(1'b0, 12'h480, 4'd1, 4'd4);
        e[1]  = ent(1'b0, 12'h000, 4'd1, 4'd5);
        e[2]  = ent(1'b0, 12'h000, 4'd2, 4'd4);
        e[3]  = ent(1'b1, 12'h000, 4'hF, 4'hF);
        e[4]  = ent(1'b1, 12'h000, 4'hF, 4'hF);
        e[5]  = ent(1'b0, 12'h000, 4'hF, 4'hF);
        e[6]  = ent(1'b0, 12'h900, 4'd2, 4'd5);
        e[7]  = ent(1'b0, 12'h000, 4'd0, 4'd5);
        e[8]  = ent(1'b0, 12'h000, 4'd2, 4'd3);
        e[9]  = ent(1'b0, 12'h000, 4'hF, 4'd0);
        e[10] = ent(1'b0, 12'h000, 4'hF, 4'd0);
        e[11] = ent(1'b0, 12'h000, 4'hF, 4'd0);
        e[12] = ent(1'b0, 12'h240, 4'd0, 4'd3);
        e[13] = ent(1'b0, 12'h000, 4'd0, 4'd4);
        e[14] = ent(1'b0, 12'h000, 4'd1, 4'd3);
        e[15] = ent(1'b0, 12'h000, 4'd0, 4'hF);
        e[16] = ent(1'b0, 12'h000, 4'hF, 4'hF);
        e[17] = ent(1'b0, 12'h000, 4'hF, 4'hF);
        for (int k = 0; k < 18; k++) t[21*k +: 21] = e[k];
        return t;
    endfunction

    localparam logic [41:0] T_FN = {ent(1'b1, 12'h040, 4'hF, 4'hF), ent(1'b0, 12'h000, 4'd0, 4'd3)};
    localparam logic [12*21-1:0] T_ID = id_table();
    localparam logic [18*21-1:0] T_PR = prince_table();

    // Single-lane configurations share one stimulus bus.
    logic        s_flush = 1'b0, s_valid = 1'b0, s_oready = 1'b0;
    logic [11:0] s_x = '0;
    logic        fn_ready, fn_ovalid, cmp_ready, cmp_ovalid, cb_ready, cb_ovalid;
    logic [1:0]  fn_q, cb_q;
    logic [0:0]  cmp_q;

    logic        p_flush = 1'b0, p_valid = 1'b0, p_oready = 1'b0;
    logic [23:0] p_x = '0;
    logic        p_ready, p_ovalid;
    logic [23:0] p_q;

    logic         r_flush = 1'b0, r_valid = 1'b0, r_oready = 1'b0;
    logic [191:0] r_x = '0;
    logic         r_ready, r_ovalid;
    logic [47:0]  r_q;

    logic [23:0] exp_q[$];

    nf_cf_array #(.CHANNELS(1), .NUM_FN(2), .GROUP(1), .OUT_REG(1), .FN_TABLE(T_FN)) dut_fn (
        .clk(clk), .rst(rst), .flush(s_flush), .in_valid(s_valid), .in_ready(fn_ready),
        .in_x(s_x), .out_valid(fn_ovalid), .out_ready(s_oready), .out_q(fn_q));

    nf_cf_array #(.CHANNELS(1), .NUM_FN(2), .GROUP(2), .OUT_REG(1), .FN_TABLE(T_FN)) dut_cmp (
        .clk(clk), .rst(rst), .flush(s_flush), .in_valid(s_valid), .in_ready(cmp_ready),
        .in_x(s_x), .out_valid(cmp_ovalid), .out_ready(s_oready), .out_q(cmp_q));

    nf_cf_array #(.CHANNELS(1), .NUM_FN(2), .GROUP(1), .OUT_REG(0), .FN_TABLE(T_FN)) dut_comb (
        .clk(clk), .rst(rst), .flush(s_flush), .in_valid(s_valid), .in_ready(cb_ready),
        .in_x(s_x), .out_valid(cb_ovalid), .out_ready(s_oready), .out_q(cb_q));

    nf_cf_array #(.CHANNELS(2), .NUM_FN(12), .GROUP(1), .OUT_REG(1), .FN_TABLE(T_ID)) dut_pipe (
        .clk(clk), .rst(rst), .flush(p_flush), .in_valid(p_valid), .in_ready(p_ready),
        .in_x(p_x), .out_valid(p_ovalid), .out_ready(p_oready), .out_q(p_q));

    nf_cf_array #(.CHANNELS(16), .NUM_FN(18), .GROUP(6), .OUT_REG(1), .FN_TABLE(T_PR)) dut_pr (
        .clk(clk), .rst(rst), .flush(r_flush), .in_valid(r_valid), .in_ready(r_ready),
        .in_x(r_x), .out_valid(r_ovalid), .out_ready(r_oready), .out_q(r_q));

    task automatic test_reset();
        logic [4:0] rdy;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({fn_ovalid, fn_q, cmp_ovalid, cmp_q, cb_ovalid, cb_q} !== 9'h0) begin
            n_err++;
            $display("FAIL reset_small got %b want 0", {fn_ovalid, fn_q, cmp_ovalid, cmp_q, cb_ovalid, cb_q});
        end
        n_vec++;
        if ({p_ovalid, p_q, r_ovalid, r_q} !== 74'h0) begin
            n_err++;
            $display("FAIL reset_wide got %h want 0", {p_ovalid, p_q, r_ovalid, r_q});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        rdy = {fn_ready, cmp_ready, cb_ready, p_ready, r_ready};
        n_vec++;
        if (rdy !== 5'h1f) begin
            n_err++;
            $display("FAIL reset_in_ready got %b want 11111", rdy);
        end
    endtask

    task automatic test_function();
        logic [11:0] vx [3];
        logic [1:0]  ve [3];
        vx = '{12'h009, 12'h040, 12'h001};
        ve = '{2'b11, 2'b00, 2'b10};
        s_oready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_x = vx[v];
            #1;
            n_vec++;
            if (fn_ready !== 1'b1) begin
                n_err++;
                $display("FAIL fn_accept[%0d] in_ready got %b want 1", v, fn_ready);
            end
            @(negedge clk);
            s_valid = 1'b0;
            #1;
            n_vec++;
            if ({cb_ovalid, cb_q, fn_ovalid} !== {1'b1, ve[v], 1'b0}) begin
                n_err++;
                $display("FAIL fn_lat1[%0d] got cb_valid=%b cb_q=%b fn_valid=%b want 1 %b 0",
                         v, cb_ovalid, cb_q, fn_ovalid, ve[v]);
            end
            @(negedge clk);
            #1;
            n_vec++;
            if ({fn_ovalid, fn_q, cb_ovalid} !== {1'b1, ve[v], 1'b0}) begin
                n_err++;
                $display("FAIL fn_lat2[%0d] got fn_valid=%b fn_q=%b cb_valid=%b want 1 %b 0",
                         v, fn_ovalid, fn_q, cb_ovalid, ve[v]);
            end
        end
    endtask

    task automatic test_compression();
        logic [11:0] vx [3];
        logic        ve [3];
        vx = '{12'h009, 12'h001, 12'h040};
        ve = '{1'b0, 1'b1, 1'b0};
        s_oready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_x = vx[v];
            @(negedge clk);
            s_valid = 1'b0;
            @(negedge clk);
            #1;
            n_vec++;
            if ({cmp_ovalid, cmp_q} !== {1'b1, ve[v]}) begin
                n_err++;
                $display("FAIL cmp[%0d] got valid=%b q=%b want 1 %b", v, cmp_ovalid, cmp_q, ve[v]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] vals [8];
        logic [23:0] held;
        logic [23:0] e;
        logic        stalled_prev;
        int sent, got;
        vals = '{24'h123456, 24'hABCDEF, 24'h000FFF, 24'hFFF000,
                 24'h5A5A5A, 24'hA5A5A5, 24'h0F0F0F, 24'h3C3C3C};
        sent = 0;
        got = 0;
        held = '0;
        stalled_prev = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            p_valid = (sent < 8);
            p_x = (sent < 8) ? vals[sent] : 24'h0;
            p_oready = !(cyc >= 4 && cyc <= 6);
            #1;
            if (p_ovalid && !p_oready) begin
                n_vec++;
                if (p_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_in_ready cyc %0d got %b want 0", cyc, p_ready);
                end
                if (stalled_prev) begin
                    n_vec++;
                    if (p_q !== held) begin
                        n_err++;
                        $display("FAIL stall_hold cyc %0d got %h want %h", cyc, p_q, held);
                    end
                end
                held = p_q;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (p_valid && p_ready) begin
                exp_q.push_back(p_x);
                sent++;
            end
            if (p_ovalid && p_oready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra got %h want none", p_q);
                end else begin
                    e = exp_q.pop_front();
                    if (p_q !== e) begin
                        n_err++;
                        $display("FAIL b2b_data[%0d] got %h want %h", got, p_q, e);
                    end
                end
                got++;
            end
        end
        n_vec++;
        if (got != 8 || sent != 8 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count got sent=%0d recv=%0d left=%0d want 8 8 0", sent, got, exp_q.size());
        end
        p_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (p_ovalid !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_dup got out_valid=%b q=%h want 0", p_ovalid, p_q);
            end
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        p_oready = 1'b0;
        p_valid = 1'b1;
        p_x = 24'h111AAA;
        @(negedge clk);
        p_x = 24'h222BBB;
        @(negedge clk);
        p_x = 24'h333CCC;
        p_flush = 1'b1;
        #1;
        n_vec++;
        if ({p_ovalid, p_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL flush_pre got valid=%b ready=%b want 1 0", p_ovalid, p_ready);
        end
        @(negedge clk);
        p_flush = 1'b0;
        p_valid = 1'b0;
        p_oready = 1'b1;
        #1;
        n_vec++;
        if ({p_ovalid, p_q} !== {1'b0, 24'h111AAA}) begin
            n_err++;
            $display("FAIL flush_clear got valid=%b q=%h want 0 111aaa", p_ovalid, p_q);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (p_ovalid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_emit cycle %0d got valid=%b want 0", i, p_ovalid);
            end
        end
        @(negedge clk);
        p_valid = 1'b1;
        p_x = 24'h444DDD;
        p_flush = 1'b1;
        #1;
        n_vec++;
        if (p_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_empty_ready got %b want 1", p_ready);
        end
        @(negedge clk);
        p_valid = 1'b0;
        p_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (p_ovalid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_drop cycle %0d got valid=%b want 0", i, p_ovalid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midstream();
        p_oready = 1'b0;
        p_valid = 1'b1;
        p_x = 24'h5E5E01;
        @(negedge clk);
        p_x = 24'h5E5E02;
        @(negedge clk);
        p_valid = 1'b0;
        #1;
        n_vec++;
        if ({p_ovalid, p_q} !== {1'b1, 24'h5E5E01}) begin
            n_err++;
            $display("FAIL pre_reset got valid=%b q=%h want 1 5e5e01", p_ovalid, p_q);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({p_ovalid, p_q} !== 25'h0) begin
            n_err++;
            $display("FAIL reset_immediate got valid=%b q=%h want 0 0", p_ovalid, p_q);
        end
        @(negedge clk);
        rst = 1'b0;
        p_oready = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if (p_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready got %b want 1", p_ready);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (p_ovalid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_stale cycle %0d got valid=%b q=%h want 0", i, p_ovalid, p_q);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_prince();
        logic [11:0] x;
        logic [15:0] e, act;
        logic [23:0] popped;
        int sent, got;
        sent = 0;
        got = 0;
        exp_q.delete();
        r_oready = 1'b1;
        for (int cyc = 0; cyc < 1200 && got < 1000; cyc++) begin
            @(negedge clk);
            r_valid = (sent < 1000);
            for (int l = 0; l < 16; l++) r_x[12*l +: 12] = 12'($urandom_range(0, 4095));
            #1;
            if (r_valid && r_ready) begin
                for (int l = 0; l < 16; l++) begin
                    x = r_x[12*l +: 12];
                    e[l] = ((^x[2:0]) & (^x[5:3])) ^ (^x[8:6]) ^ (^x[11:9]);
                end
                exp_q.push_back({8'h0, e});
                sent++;
            end
            if (r_ovalid && r_oready) begin
                for (int l = 0; l < 16; l++) act[l] = ^r_q[3*l +: 3];
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL prince_extra got %h want none", act);
                end else begin
                    popped = exp_q.pop_front();
                    if (act !== popped[15:0]) begin
                        n_err++;
                        $display("FAIL prince[%0d] got %h want %h", got, act, popped[15:0]);
                    end
                end
                got++;
            end
        end
        r_valid = 1'b0;
        n_vec++;
        if (got != 1000 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL prince_count got recv=%0d left=%0d want 1000 0", got, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_function();
        test_compression();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_prince();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
